// File: rtl/pulse_channel_gen_if.sv
// Pulse channel register/sample bundle.
// master: register file / sequencer side (drives strobes and channel registers, reads sample).
// slave : pulse_channel_gen (reads strobes and registers, drives sample/active/frequency).
interface pulse_channel_gen_if #(
  parameter int unsigned SAMPLE_W = 20,
  parameter int unsigned PERIOD_W = 11
);
  logic                I_STROBE;
  logic                I_FRAME_TICK;
  logic                I_TRIGGER;
  logic                I_WAVEFORM_EN;
  logic [PERIOD_W-1:0] I_FREQUENCY;
  logic [1:0]          I_DUTY_CYCLE;
  logic [3:0]          I_ENV_INIT;
  logic                I_ENV_DIR;
  logic [2:0]          I_ENV_PERIOD;
  logic [5:0]          I_LENGTH;
  logic                I_LENGTH_EN;
  logic [2:0]          I_SWEEP_PERIOD;
  logic                I_SWEEP_DIR;
  logic [2:0]          I_SWEEP_SHIFT;
  logic [SAMPLE_W-1:0] O_SAMPLE;
  logic                O_ACTIVE;
  logic [PERIOD_W-1:0] O_FREQUENCY;

  modport master (
    output I_STROBE, I_FRAME_TICK, I_TRIGGER, I_WAVEFORM_EN, I_FREQUENCY, I_DUTY_CYCLE,
           I_ENV_INIT, I_ENV_DIR, I_ENV_PERIOD, I_LENGTH, I_LENGTH_EN,
           I_SWEEP_PERIOD, I_SWEEP_DIR, I_SWEEP_SHIFT,
    input  O_SAMPLE, O_ACTIVE, O_FREQUENCY
  );

  modport slave (
    input  I_STROBE, I_FRAME_TICK, I_TRIGGER, I_WAVEFORM_EN, I_FREQUENCY, I_DUTY_CYCLE,
           I_ENV_INIT, I_ENV_DIR, I_ENV_PERIOD, I_LENGTH, I_LENGTH_EN,
           I_SWEEP_PERIOD, I_SWEEP_DIR, I_SWEEP_SHIFT,
    output O_SAMPLE, O_ACTIVE, O_FREQUENCY
  );
endinterface

// File: rtl/pulse_channel_gen.sv
// Game Boy style pulse (square) channel: 8-step duty sequencer with arithmetic period,
// trigger, length counter, volume envelope and optional frequency sweep, clocked by a
// 512 Hz frame tick.
// Ports:
//   I_BITCLK - clock
//   I_RESET  - synchronous, active-high reset
//   bus      - pulse_channel_gen_if.slave: strobes, channel registers, O_SAMPLE (signed),
//              O_ACTIVE, O_FREQUENCY (shadow frequency)
module pulse_channel_gen #(
  parameter int unsigned          SAMPLE_W  = 20,
  parameter int unsigned          PERIOD_W  = 11,
  parameter bit                   HAS_SWEEP = 1'b1,
  parameter logic [SAMPLE_W-1:0]  AMP_STEP  = 20'h02222
) (
  input logic                I_BITCLK,
  input logic                I_RESET,
  pulse_channel_gen_if.slave bus
);

  localparam logic [PERIOD_W:0] FullPeriod = {1'b1, {PERIOD_W{1'b0}}};
  localparam logic [PERIOD_W:0] TimerOne   = {{PERIOD_W{1'b0}}, 1'b1};

  logic                active_q, active_d;
  logic [PERIOD_W-1:0] shadow_q, shadow_d;
  logic [PERIOD_W:0]   timer_q, timer_d;       // one extra bit: freq 0 reloads 2^PERIOD_W
  logic [2:0]          step_q, step_d;
  logic [3:0]          vol_q, vol_d;
  logic [2:0]          env_timer_q, env_timer_d;
  logic [6:0]          len_cnt_q, len_cnt_d;
  logic [3:0]          sweep_timer_q, sweep_timer_d;  // holds 8 for a sweep period of 0
  logic [2:0]          fs_step_q, fs_step_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  logic                dac_on, trig, len_clk, sweep_clk, env_clk, duty_bit;
  logic [PERIOD_W:0]   trig_sweep, cur_sweep;
  logic [3:0]          sweep_load;
  logic [7:0]          pattern;
  logic [SAMPLE_W-1:0] mag;

  // shadow +/- (shadow >> shift); bit PERIOD_W set means overflow.
  function automatic logic [PERIOD_W:0] sweep_next(input logic [PERIOD_W-1:0] f,
                                                   input logic [2:0] sh, input logic dir);
    logic [PERIOD_W:0] base, delta;
    base  = {1'b0, f};
    delta = base >> sh;
    return dir ? (base - delta) : (base + delta);
  endfunction

  always_comb begin
    dac_on     = (bus.I_ENV_INIT != 4'd0) || bus.I_ENV_DIR;
    trig       = bus.I_TRIGGER && dac_on;
    // Frame sequencer decode uses the step value before this tick's increment.
    len_clk    = bus.I_FRAME_TICK && !fs_step_q[0];
    sweep_clk  = bus.I_FRAME_TICK && (fs_step_q[1:0] == 2'b10);
    env_clk    = bus.I_FRAME_TICK && (fs_step_q == 3'd7);
    trig_sweep = sweep_next(bus.I_FREQUENCY, bus.I_SWEEP_SHIFT, bus.I_SWEEP_DIR);
    cur_sweep  = sweep_next(shadow_q, bus.I_SWEEP_SHIFT, bus.I_SWEEP_DIR);
    sweep_load = (bus.I_SWEEP_PERIOD == 3'd0) ? 4'd8 : {1'b0, bus.I_SWEEP_PERIOD};
  end

  // Patterns written step 0 first (MSB) to step 7 (LSB).
  always_comb begin
    unique case (bus.I_DUTY_CYCLE)
      2'b00:   pattern = 8'b0000_0001;
      2'b01:   pattern = 8'b1000_0001;
      2'b10:   pattern = 8'b1000_0111;
      2'b11:   pattern = 8'b0111_1110;
      default: pattern = 8'b0000_0000;
    endcase
    duty_bit = pattern[3'd7 - step_q];
    mag      = {{(SAMPLE_W-4){1'b0}}, vol_q} * AMP_STEP;
  end

  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    timer_d       = timer_q;
    step_d        = step_q;
    vol_d         = vol_q;
    env_timer_d   = env_timer_q;
    len_cnt_d     = len_cnt_q;
    sweep_timer_d = sweep_timer_q;
    fs_step_d     = fs_step_q;
    sample_d      = '0;

    if (active_q && bus.I_WAVEFORM_EN) begin
      sample_d = duty_bit ? mag : -mag;
    end

    if (bus.I_FRAME_TICK) begin
      fs_step_d = fs_step_q + 3'd1;
    end

    if (trig) begin
      // Trigger loads override the strobe and frame-clock updates of this cycle.
      active_d      = 1'b1;
      shadow_d      = bus.I_FREQUENCY;
      timer_d       = FullPeriod - {1'b0, bus.I_FREQUENCY};
      step_d        = 3'd0;
      vol_d         = bus.I_ENV_INIT;
      env_timer_d   = bus.I_ENV_PERIOD;
      len_cnt_d     = 7'd64 - {1'b0, bus.I_LENGTH};
      sweep_timer_d = HAS_SWEEP ? sweep_load : 4'd0;
      if (HAS_SWEEP && (bus.I_SWEEP_SHIFT != 3'd0) && trig_sweep[PERIOD_W]) begin
        active_d = 1'b0;
      end
    end else begin
      if (bus.I_STROBE && active_q) begin
        if (timer_q == TimerOne) begin
          timer_d = FullPeriod - {1'b0, shadow_q};
          step_d  = step_q + 3'd1;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end

      if (len_clk && bus.I_LENGTH_EN && (len_cnt_q != 7'd0)) begin
        len_cnt_d = len_cnt_q - 7'd1;
        if (len_cnt_q == 7'd1) begin
          active_d = 1'b0;
        end
      end

      if (env_clk && (bus.I_ENV_PERIOD != 3'd0)) begin
        if (env_timer_q <= 3'd1) begin
          env_timer_d = bus.I_ENV_PERIOD;
          if (bus.I_ENV_DIR) begin
            vol_d = (vol_q == 4'd15) ? vol_q : vol_q + 4'd1;
          end else begin
            vol_d = (vol_q == 4'd0) ? vol_q : vol_q - 4'd1;
          end
        end else begin
          env_timer_d = env_timer_q - 3'd1;
        end
      end

      if (HAS_SWEEP && sweep_clk) begin
        if (sweep_timer_q <= 4'd1) begin
          sweep_timer_d = sweep_load;
          if (bus.I_SWEEP_PERIOD != 3'd0) begin
            if (cur_sweep[PERIOD_W]) begin
              active_d = 1'b0;
            end else if (bus.I_SWEEP_SHIFT != 3'd0) begin
              shadow_d = cur_sweep[PERIOD_W-1:0];
            end
          end
        end else begin
          sweep_timer_d = sweep_timer_q - 4'd1;
        end
      end
    end

    if (!dac_on) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge I_BITCLK) begin
    if (I_RESET) begin
      active_q      <= 1'b0;
      shadow_q      <= '0;
      timer_q       <= '0;
      step_q        <= 3'd0;
      vol_q         <= 4'd0;
      env_timer_q   <= 3'd0;
      len_cnt_q     <= 7'd0;
      sweep_timer_q <= 4'd0;
      fs_step_q     <= 3'd0;
      sample_q      <= '0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      timer_q       <= timer_d;
      step_q        <= step_d;
      vol_q         <= vol_d;
      env_timer_q   <= env_timer_d;
      len_cnt_q     <= len_cnt_d;
      sweep_timer_q <= sweep_timer_d;
      fs_step_q     <= fs_step_d;
      sample_q      <= sample_d;
    end
  end

  assign bus.O_SAMPLE    = sample_q;
  assign bus.O_ACTIVE    = active_q;
  assign bus.O_FREQUENCY = shadow_q;

endmodule

// File: tb/tb_pulse_channel_gen.sv
module tb_pulse_channel_gen;

  typedef struct {
    logic [19:0] sample;
    logic        active;
    logic [10:0] freq;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, strobe = 1'b0, tick = 1'b0, trig = 1'b0, wen = 1'b1;
  logic [10:0] freq = '0;
  logic [1:0]  duty = '0;
  logic [3:0]  einit = '0;
  logic        edir = 1'b0, len_en = 1'b0, sdir = 1'b0;
  logic [2:0]  eper = '0, sper = '0, sshift = '0;
  logic [5:0]  len = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Channel index 0: no sweep (ifn), 1: with sweep (ifs).
  pulse_channel_gen_if #(.SAMPLE_W(20), .PERIOD_W(11)) ifn ();
  pulse_channel_gen_if #(.SAMPLE_W(20), .PERIOD_W(11)) ifs ();

  assign ifn.I_STROBE = strobe;       assign ifs.I_STROBE = strobe;
  assign ifn.I_FRAME_TICK = tick;     assign ifs.I_FRAME_TICK = tick;
  assign ifn.I_TRIGGER = trig;        assign ifs.I_TRIGGER = trig;
  assign ifn.I_WAVEFORM_EN = wen;     assign ifs.I_WAVEFORM_EN = wen;
  assign ifn.I_FREQUENCY = freq;      assign ifs.I_FREQUENCY = freq;
  assign ifn.I_DUTY_CYCLE = duty;     assign ifs.I_DUTY_CYCLE = duty;
  assign ifn.I_ENV_INIT = einit;      assign ifs.I_ENV_INIT = einit;
  assign ifn.I_ENV_DIR = edir;        assign ifs.I_ENV_DIR = edir;
  assign ifn.I_ENV_PERIOD = eper;     assign ifs.I_ENV_PERIOD = eper;
  assign ifn.I_LENGTH = len;          assign ifs.I_LENGTH = len;
  assign ifn.I_LENGTH_EN = len_en;    assign ifs.I_LENGTH_EN = len_en;
  assign ifn.I_SWEEP_PERIOD = sper;   assign ifs.I_SWEEP_PERIOD = sper;
  assign ifn.I_SWEEP_DIR = sdir;      assign ifs.I_SWEEP_DIR = sdir;
  assign ifn.I_SWEEP_SHIFT = sshift;  assign ifs.I_SWEEP_SHIFT = sshift;

  pulse_channel_gen #(.SAMPLE_W(20), .PERIOD_W(11), .HAS_SWEEP(1'b0), .AMP_STEP(20'h02222))
    u_ch2 (.I_BITCLK(clk), .I_RESET(rst), .bus(ifn));
  pulse_channel_gen #(.SAMPLE_W(20), .PERIOD_W(11), .HAS_SWEEP(1'b1), .AMP_STEP(20'h02222))
    u_ch1 (.I_BITCLK(clk), .I_RESET(rst), .bus(ifs));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // Timers are modelled as "events elapsed since load" against a latched target count.
  string duty_pat[4] = '{"00000001", "10000001", "10000111", "01111110"};
  int m_act[2], m_shadow[2], m_phase[2], m_intv[2], m_step[2], m_vol[2];
  int m_env_n[2], m_env_load[2], m_len[2], m_sw_n[2], m_sw_load[2], m_fs[2];
  exp_t sb0[$], sb1[$];

  function automatic int sweep_calc(input int f);
    int d;
    d = f >> sshift;
    return sdir ? (f - d) : (f + d);
  endfunction

  task automatic model_cycle(input int c);
    exp_t e;
    int mag;
    bit hs, dac_on, tr, lclk, sclk, eclk;
    hs = (c == 1);
    if (rst) begin
      m_act[c] = 0; m_shadow[c] = 0; m_phase[c] = 0; m_intv[c] = 0; m_step[c] = 0;
      m_vol[c] = 0; m_env_n[c] = 0; m_env_load[c] = 0; m_len[c] = 0; m_sw_n[c] = 0;
      m_sw_load[c] = 0; m_fs[c] = 0;
      e.sample = '0; e.active = 1'b0; e.freq = '0;
    end else begin
      mag = m_vol[c] * 'h2222;
      if (m_act[c] != 0 && wen)
        e.sample = (duty_pat[duty].getc(m_step[c]) == "1") ? 20'(mag) : 20'(-mag);
      else
        e.sample = '0;
      dac_on = (einit != 0) || edir;
      tr     = trig && dac_on;
      lclk   = tick && (m_fs[c] % 2 == 0);
      sclk   = tick && (m_fs[c] == 2 || m_fs[c] == 6);
      eclk   = tick && (m_fs[c] == 7);
      if (tick) m_fs[c] = (m_fs[c] + 1) % 8;
      if (tr) begin
        m_act[c] = 1; m_shadow[c] = freq; m_phase[c] = 0; m_intv[c] = 2048 - freq;
        m_step[c] = 0; m_vol[c] = einit; m_env_load[c] = eper; m_env_n[c] = 0;
        m_len[c] = 64 - len; m_sw_load[c] = (sper == 0) ? 8 : sper; m_sw_n[c] = 0;
        if (hs && sshift != 0 && sweep_calc(freq) > 2047) m_act[c] = 0;
      end else begin
        if (strobe && m_act[c] != 0) begin
          m_phase[c]++;
          if (m_phase[c] == m_intv[c]) begin
            m_phase[c] = 0; m_intv[c] = 2048 - m_shadow[c]; m_step[c] = (m_step[c] + 1) % 8;
          end
        end
        if (lclk && len_en && m_len[c] != 0) begin
          m_len[c]--;
          if (m_len[c] == 0) m_act[c] = 0;
        end
        if (eclk && eper != 0) begin
          m_env_n[c]++;
          if (m_env_n[c] >= m_env_load[c]) begin
            m_env_n[c] = 0; m_env_load[c] = eper;
            m_vol[c] = edir ? ((m_vol[c] < 15) ? m_vol[c] + 1 : 15)
                            : ((m_vol[c] > 0) ? m_vol[c] - 1 : 0);
          end
        end
        if (hs && sclk) begin
          m_sw_n[c]++;
          if (m_sw_n[c] >= m_sw_load[c]) begin
            m_sw_n[c] = 0; m_sw_load[c] = (sper == 0) ? 8 : sper;
            if (sper != 0) begin
              if (sweep_calc(m_shadow[c]) > 2047) m_act[c] = 0;
              else if (sshift != 0) m_shadow[c] = sweep_calc(m_shadow[c]);
            end
          end
        end
      end
      if (!dac_on) m_act[c] = 0;
      e.active = (m_act[c] != 0);
      e.freq   = 11'(m_shadow[c]);
    end
    if (c == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  always @(posedge clk) begin
    model_cycle(0);
    model_cycle(1);
  end

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() == 0 || sb1.size() == 0) begin
      chk("sb_underflow", 32'(sb0.size() + sb1.size()), 32'd2);
    end else begin
      e = sb0.pop_front();
      chk("ch2_sample", {12'b0, ifn.O_SAMPLE}, {12'b0, e.sample});
      chk("ch2_active", {31'b0, ifn.O_ACTIVE}, {31'b0, e.active});
      chk("ch2_freq", {21'b0, ifn.O_FREQUENCY}, {21'b0, e.freq});
      e = sb1.pop_front();
      chk("ch1_sample", {12'b0, ifs.O_SAMPLE}, {12'b0, e.sample});
      chk("ch1_active", {31'b0, ifs.O_ACTIVE}, {31'b0, e.active});
      chk("ch1_freq", {21'b0, ifs.O_FREQUENCY}, {21'b0, e.freq});
    end
  end

  // ---------------- Stimulus ----------------
  task automatic cyc(input logic s, input logic t, input logic tr);
    strobe = s; tick = t; trig = tr;
    @(negedge clk);
    strobe = 1'b0; tick = 1'b0; trig = 1'b0;
  endtask

  logic [19:0] seq1 [8] = '{20'h1FFFE, 20'hE0002, 20'hE0002, 20'hE0002,
                            20'hE0002, 20'h1FFFE, 20'h1FFFE, 20'h1FFFE};

  initial begin
    // Reset state
    duty = 2'b10; freq = 11'd2047; einit = 4'd15;
    repeat (3) @(negedge clk);
    chk("rst_sample", {12'b0, ifn.O_SAMPLE}, 32'd0);
    chk("rst_active", {31'b0, ifn.O_ACTIVE}, 32'd0);
    chk("rst_freq", {21'b0, ifs.O_FREQUENCY}, 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Duty 10, reload 1: one step per strobe
    cyc(1'b0, 1'b0, 1'b1);
    chk("trig_active", {31'b0, ifn.O_ACTIVE}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("duty10_step%0d", i), {12'b0, ifn.O_SAMPLE}, {12'b0, seq1[i]});
    end

    // Reload 4: 32 strobes -> 8 steps, back to step 0
    freq = 11'd2044;
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("reload4_step0", {12'b0, ifn.O_SAMPLE}, 32'h1FFFE);

    // Length 62 -> expires on the second length clock
    len = 6'd62; len_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16 && ifn.O_ACTIVE; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("len_expiry", {31'b0, ifn.O_ACTIVE}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("len_sample0", {12'b0, ifn.O_SAMPLE}, 32'd0);

    // Envelope 2 down, period 1 -> decays to 0 and stays
    len_en = 1'b0; einit = 4'd2; edir = 1'b0; eper = 3'd1;
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'(i % 2), 1'b0);
    chk("env_active", {31'b0, ifn.O_ACTIVE}, 32'd1);
    chk("env_vol0_sample", {12'b0, ifn.O_SAMPLE}, 32'd0);

    // Sweep: 0x700 overflows at trigger; 0x400 sweeps to 0x600 then overflows
    einit = 4'd15; eper = 3'd0; sshift = 3'd1; sdir = 1'b0; sper = 3'd1; freq = 11'h700;
    cyc(1'b0, 1'b0, 1'b1);
    chk("sw_trig_ovf_active", {31'b0, ifs.O_ACTIVE}, 32'd0);
    chk("sw_trig_ovf_freq", {21'b0, ifs.O_FREQUENCY}, 32'h700);
    chk("nosw_active", {31'b0, ifn.O_ACTIVE}, 32'd1);
    freq = 11'h400;
    cyc(1'b0, 1'b0, 1'b1);
    chk("sw_trig_ok_active", {31'b0, ifs.O_ACTIVE}, 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("sw_final_freq", {21'b0, ifs.O_FREQUENCY}, 32'h600);
    chk("sw_final_active", {31'b0, ifs.O_ACTIVE}, 32'd0);

    // Trigger with strobe and frame tick, then reset mid-note
    freq = 11'd2044; sshift = 3'd0;
    cyc(1'b1, 1'b1, 1'b1);
    chk("coinc_active", {31'b0, ifn.O_ACTIVE}, 32'd1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sample", {12'b0, ifn.O_SAMPLE}, 32'd0);
    chk("midrst_active", {31'b0, ifs.O_ACTIVE}, 32'd0);
    chk("midrst_freq", {21'b0, ifn.O_FREQUENCY}, 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 599) == 0);
      strobe = 1'($urandom_range(0, 1));
      tick   = ($urandom_range(0, 3) == 0);
      trig   = ($urandom_range(0, 39) == 0);
      wen    = ($urandom_range(0, 15) != 0);
      duty   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        freq   = ($urandom_range(0, 1) == 1) ? 11'(2048 - $urandom_range(1, 8))
                                             : 11'($urandom_range(0, 2047));
        einit  = 4'($urandom_range(0, 15));
        edir   = 1'($urandom_range(0, 1));
        eper   = 3'($urandom_range(0, 7));
        len    = 6'($urandom_range(0, 63));
        len_en = 1'($urandom_range(0, 1));
        sper   = 3'($urandom_range(0, 7));
        sdir   = 1'($urandom_range(0, 1));
        sshift = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    rst = 1'b0; strobe = 1'b0; tick = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
